// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: the pipeline MEM stage has fixed priority over a
// loader/debug requester, except that a starvation counter forces a loader
// grant after STARVE_LIMIT consecutive losses. The single-port memory is
// driven from the winner; read data and completion strobes are registered.
module dmem_port_arbiter #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_valid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err
);

    typedef enum logic [1:0] {IDLE, P_DONE, L_DONE} arbStateT;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthLim  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      StarveLim = 4'(STARVE_LIMIT);

    arbStateT          state, stateNext;
    logic [3:0]        starveCnt;
    logic              grantL, grantP, winner, winWe, outOfRange;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winWdata;
    logic [DATA_W-1:0] pRdata_p1, lRdata_p1;
    logic [DATA_W-1:0] accessData;
    logic              addrErr;

    // Arbitration and winner operand selection.
    always_comb begin
        grantL     = l_req && (!p_req || (starveCnt >= StarveLim));
        grantP     = p_req && !grantL;
        winner     = grantL || grantP;
        winWe      = grantL ? l_we    : p_we;
        winAddr    = grantL ? l_addr  : p_addr;
        winWdata   = grantL ? l_wdata : p_wdata;
        outOfRange = winner && ({1'b0, winAddr} >= DepthLim);
        p_stall    = p_req && !grantP;
    end

    // Memory drive: idle bus is all zeros; out-of-range accesses are suppressed.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (winner) begin
            mem_addr  = winAddr;
            mem_wdata = winWdata;
            mem_we    = winWe && !outOfRange;
            mem_re    = !winWe && !outOfRange;
        end
    end

    // Data returned on completion: memory read data, or zero for writes and suppressed accesses.
    always_comb begin
        accessData = (winWe || outOfRange) ? '0 : mem_rdata;
    end

    // Next state remembers which requester was served this cycle.
    always_comb begin
        stateNext = IDLE;
        if (grantL) begin
            stateNext = L_DONE;
        end else if (grantP) begin
            stateNext = P_DONE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Starvation counter: counts consecutive loader losses, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= 4'd0;
        end else if (!l_req || grantL) begin
            starveCnt <= 4'd0;
        end else if (starveCnt < StarveLim) begin
            starveCnt <= starveCnt + 4'd1;
        end
    end

    // ---- grant cycle -> completion cycle (_p1) ----
    // Read data registers, each updated only when its requester completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pRdata_p1 <= '0;
            lRdata_p1 <= '0;
        end else begin
            if (grantP) begin
                pRdata_p1 <= accessData;
            end
            if (grantL) begin
                lRdata_p1 <= accessData;
            end
        end
    end

    // Sticky out-of-range flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrErr <= 1'b0;
        end else if (outOfRange) begin
            addrErr <= 1'b1;
        end
    end

    // Completion strobes decoded from the registered state.
    always_comb begin
        p_valid  = (state == P_DONE);
        l_ack    = (state == L_DONE);
        p_rdata  = pRdata_p1;
        l_rdata  = lRdata_p1;
        addr_err = addrErr;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: plays the single-port memory, drives directed
// and random traffic, and compares against a rule-level reference model.
module tb_dmem_port_arbiter;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 64;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p_req, p_we, p_stall, p_valid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic          l_req, l_we, l_ack;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, mem_re, addr_err;

    logic [DW-1:0] physMem [DEPTH];
    logic [DW-1:0] refMem  [DEPTH];

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state
    int            mCnt;
    bit            mErr;
    bit            expPValid, expLAck;
    logic [DW-1:0] expPRdata, expLRdata;

    dmem_port_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_stall(p_stall), .p_valid(p_valid), .p_rdata(p_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    // Single-port memory acting on the falling edge; junk on the bus when not reading.
    always @(negedge clk) begin
        if (mem_we && int'(mem_addr) < DEPTH) physMem[int'(mem_addr)] = mem_wdata;
        if (mem_re && int'(mem_addr) < DEPTH) mem_rdata = physMem[int'(mem_addr)];
        else mem_rdata = 16'hDEAD;
    end

    function automatic logic [DW-1:0] initVal(int i);
        return 16'((i * 257) ^ 'hA5A5);
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        mCnt = 0; mErr = 0; expPValid = 0; expLAck = 0;
        expPRdata = '0; expLRdata = '0;
    endtask

    // Runs one clock cycle; entered and left 1 time unit after a rising edge.
    task automatic stepCycle();
        bit            gL, gP, win, we, oor;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd;
        #2;
        gL  = l_req && (!p_req || mCnt >= LIMIT);
        gP  = p_req && !gL;
        win = gL || gP;
        we  = gL ? l_we : p_we;
        a   = gL ? l_addr : p_addr;
        wd  = gL ? l_wdata : p_wdata;
        oor = win && (int'(a) >= DEPTH);
        checkVal("p_stall",   32'(p_stall),   32'(p_req && !gP));
        checkVal("mem_we",    32'(mem_we),    32'(win && we && !oor));
        checkVal("mem_re",    32'(mem_re),    32'(win && !we && !oor));
        checkVal("mem_addr",  32'(mem_addr),  32'(win ? a : 16'h0));
        checkVal("mem_wdata", 32'(mem_wdata), 32'(win ? wd : 16'h0));
        expPValid = gP;
        expLAck   = gL;
        if (win) begin
            if (we || oor) rd = '0;
            else rd = refMem[int'(a)];
            if (we && !oor) refMem[int'(a)] = wd;
            if (gP) expPRdata = rd;
            else expLRdata = rd;
            if (oor) mErr = 1;
        end
        if (!l_req || gL) mCnt = 0;
        else mCnt = (mCnt < LIMIT) ? mCnt + 1 : LIMIT;
        @(posedge clk);
        #1;
        checkVal("p_valid",  32'(p_valid),  32'(expPValid));
        checkVal("l_ack",    32'(l_ack),    32'(expLAck));
        checkVal("p_rdata",  32'(p_rdata),  32'(expPRdata));
        checkVal("l_rdata",  32'(l_rdata),  32'(expLRdata));
        checkVal("addr_err", 32'(addr_err), 32'(mErr));
    endtask

    initial begin
        int steps, pvCount;
        p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            physMem[i] = initVal(i);
            refMem[i]  = initVal(i);
        end
        resetModel();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_p_valid",  32'(p_valid),  32'(0));
        checkVal("rst_l_ack",    32'(l_ack),    32'(0));
        checkVal("rst_addr_err", 32'(addr_err), 32'(0));
        checkVal("rst_p_rdata",  32'(p_rdata),  32'(0));
        checkVal("rst_l_rdata",  32'(l_rdata),  32'(0));
        rst_n = 1;

        // Pipeline write then read of addr 5
        p_req = 1; p_we = 1; p_addr = 16'd5; p_wdata = 16'h1234;
        stepCycle();
        p_we = 0;
        stepCycle();
        checkVal("tp1_rdata", 32'(p_rdata), 32'h1234);
        p_req = 0;
        stepCycle();

        // Starvation: loader read of addr 9 against a continuous pipeline
        l_req = 1; l_we = 0; l_addr = 16'd9;
        steps = 0;
        for (int k = 0; k < 20; k++) begin
            p_req = 1; p_we = 0; p_addr = 16'($urandom_range(0, DEPTH - 1));
            stepCycle();
            steps++;
            if (l_ack) break;
        end
        checkVal("starve_lat", 32'(steps), 32'd5);
        checkVal("starve_rdata", 32'(l_rdata), 32'(initVal(9)));
        l_req = 0;
        stepCycle();
        p_req = 0;
        stepCycle();

        // Loader write 0xBEEF to addr 63, pipeline reads it back
        l_req = 1; l_we = 1; l_addr = 16'd63; l_wdata = 16'hBEEF;
        stepCycle();
        checkVal("tp3_ack", 32'(l_ack), 32'd1);
        l_req = 0;
        p_req = 1; p_we = 0; p_addr = 16'd63;
        stepCycle();
        checkVal("tp3_rdata", 32'(p_rdata), 32'hBEEF);
        p_req = 0;

        // Loader read out of range
        l_req = 1; l_we = 0; l_addr = 16'd64;
        stepCycle();
        checkVal("tp4_err",   32'(addr_err), 32'd1);
        checkVal("tp4_rdata", 32'(l_rdata),  32'd0);
        l_req = 0;
        repeat (3) stepCycle();

        // Back-to-back pipeline reads of 0..8
        pvCount = 0;
        for (int i = 0; i <= 8; i++) begin
            p_req = 1; p_we = 0; p_addr = 16'(i);
            stepCycle();
            if (p_valid) pvCount++;
        end
        checkVal("b2b_valid", 32'(pvCount), 32'd9);
        p_req = 0;
        stepCycle();

        // Random mixed traffic with a protocol-abiding loader
        for (int c = 0; c < 500; c++) begin
            if (l_ack) begin
                l_req = 0;
            end else if (!l_req && $urandom_range(0, 3) == 0) begin
                l_req   = 1;
                l_we    = 1'($urandom_range(0, 1));
                l_addr  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(DEPTH, DEPTH + 8))
                                                       : 16'($urandom_range(0, DEPTH - 1));
                l_wdata = 16'($urandom);
            end
            p_req   = ($urandom_range(0, 9) < 7);
            p_we    = 1'($urandom_range(0, 1));
            p_addr  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(DEPTH, DEPTH + 8))
                                                   : 16'($urandom_range(0, DEPTH - 1));
            p_wdata = 16'($urandom);
            stepCycle();
        end
        l_req = 0; p_req = 0;
        repeat (2) stepCycle();

        // Reset asserted after a pipeline write has committed in its grant cycle
        p_req = 1; p_we = 1; p_addr = 16'd20; p_wdata = 16'h5A5A;
        #2;
        checkVal("rst_mid_stall", 32'(p_stall), 32'd0);
        #5;
        rst_n = 0;
        #1;
        checkVal("rst_mid_p_valid",  32'(p_valid),  32'd0);
        checkVal("rst_mid_l_ack",    32'(l_ack),    32'd0);
        checkVal("rst_mid_addr_err", 32'(addr_err), 32'd0);
        checkVal("rst_mid_p_rdata",  32'(p_rdata),  32'd0);
        checkVal("rst_mid_l_rdata",  32'(l_rdata),  32'd0);
        p_req = 0;
        @(posedge clk);
        #1;
        checkVal("rst_mid_no_valid", 32'(p_valid), 32'd0);
        checkVal("rst_mid_commit", 32'(physMem[20]), 32'h5A5A);
        refMem[20] = 16'h5A5A;
        resetModel();
        rst_n = 1;
        stepCycle();

        // Counter restarts from zero after reset
        l_req = 1; l_we = 0; l_addr = 16'd20;
        steps = 0;
        for (int k = 0; k < 20; k++) begin
            p_req = 1; p_we = 0; p_addr = 16'($urandom_range(0, DEPTH - 1));
            stepCycle();
            steps++;
            if (l_ack) break;
        end
        checkVal("post_rst_starve_lat", 32'(steps), 32'd5);
        checkVal("post_rst_rdata", 32'(l_rdata), 32'h5A5A);
        l_req = 0; p_req = 0;
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
